// File: rtl/fifo_rdstream_pkg.sv
// Shared definitions for FIFO read-side controllers.
// State encodings are common to every sibling controller.
package fifo_rdstream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rd_state_e;

   localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/rdstream_skid2.sv
// Two-entry in-order output buffer.
// Entry 0 is always the oldest word.
module rdstream_skid2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [1:0]       occ_o
);

   logic [WIDTH-1:0] e0_q, e0_d;
   logic [WIDTH-1:0] e1_q, e1_d;
   logic [1:0]       occ_q, occ_d;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop_i && (occ_q != 2'd0);
   assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      occ_d = occ_q;
      unique case ({push_ok, pop_ok})
         2'b11: begin
            if (occ_q == 2'd2) begin
               e0_d = e1_q;
               e1_d = din_i;
            end else begin
               e0_d = din_i;
            end
         end
         2'b10: begin
            if (occ_q == 2'd0) e0_d = din_i;
            else               e1_d = din_i;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         e0_q  <= '0;
         e1_q  <= '0;
         occ_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         occ_q <= occ_d;
      end
   end

   assign dout_o = e0_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rdstream.sv
// Streams rdnum words from a 1-cycle-latency FIFO
// to a valid/ready sink through a 2-entry buffer.
module fifo_rdstream
   import fifo_rdstream_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int CNTBIT = 8
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              start,
   input  logic [CNTBIT-1:0] rdnum,
   input  logic              notempty,
   input  logic [WIDTH-1:0]  fifodout,
   output logic              fiford,
   output logic              dvalid,
   output logic [WIDTH-1:0]  ddata,
   input  logic              dready,
   output logic              busy,
   output logic              done,
   output logic [CNTBIT-1:0] delcnt
);

   rd_state_e         state_q, state_d;
   logic [CNTBIT-1:0] len_q, len_d;
   logic [CNTBIT-1:0] iss_q, iss_d;
   logic [CNTBIT-1:0] del_q, del_d;
   logic              infl_q;
   logic [1:0]        occ;
   logic              pop;
   logic [2:0]        level;

   assign dvalid = (occ != 2'd0);
   assign pop    = dvalid && dready;

   // Words that will sit in the buffer after this edge, before any new read
   assign level = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

   assign fiford = (state_q == ST_RUN) && notempty &&
                   (iss_q < len_q) && (level < 3'(SKID_DEPTH));

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign delcnt = del_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      iss_d   = iss_q;
      del_d   = del_q;
      if (fiford) iss_d = iss_q + CNTBIT'(1);
      if (pop)    del_d = del_q + CNTBIT'(1);
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = rdnum;
               iss_d   = '0;
               del_d   = '0;
               state_d = (rdnum == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (pop && ((del_q + CNTBIT'(1)) == len_q))
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         iss_q   <= '0;
         del_q   <= '0;
         infl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         del_q   <= del_d;
         infl_q  <= fiford;
      end
   end

   rdstream_skid2 #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk    (clk),
      .rst_   (rst_),
      .push_i (infl_q),
      .din_i  (fifodout),
      .pop_i  (pop),
      .dout_o (ddata),
      .occ_o  (occ)
   );

endmodule

// File: tb/tb_fifo_rdstream.sv
// Directed bench for fifo_rdstream with a FIFO model
// and a transfer-level reference checked every cycle.
module tb_fifo_rdstream;

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       start = 1'b0;
   logic [7:0] rdnum = 8'h00;
   logic       notempty;
   logic [7:0] fifodout = 8'h00;
   logic       fiford;
   logic       dvalid;
   logic [7:0] ddata;
   logic       dready = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] delcnt;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   always #5 clk = ~clk;

   fifo_rdstream #(.WIDTH(8), .CNTBIT(8)) dut (
      .clk      (clk),
      .rst_     (rst_),
      .start    (start),
      .rdnum    (rdnum),
      .notempty (notempty),
      .fifodout (fifodout),
      .fiford   (fiford),
      .dvalid   (dvalid),
      .ddata    (ddata),
      .dready   (dready),
      .busy     (busy),
      .done     (done),
      .delcnt   (delcnt)
   );

   // FIFO with registered read data; garbage when not read
   assign notempty = (wr_ptr != rd_ptr);
   always @(posedge clk) begin
      if (fiford) begin
         fifodout <= mem[rd_ptr[7:0]];
         rd_ptr   <= rd_ptr + 1;
      end else begin
         fifodout <= 8'hEE;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Transfer-level reference: phase 0 idle, 1 running, 2 done pulse
   int ph = 0;
   int m_len = 0;
   int m_iss = 0;
   int m_del = 0;
   int exp_idx = 0;
   logic hold = 1'b0;
   logic [7:0] hold_d = 8'h00;

   always @(negedge clk) begin
      if (!rst_) begin
         chk("rst_outs", {fiford, dvalid, busy, done, ddata, delcnt}, 0);
         ph = 0; m_del = 0; m_iss = 0; m_len = 0;
         exp_idx = rd_ptr; hold = 1'b0;
      end else begin
         chk("busy", busy, ph != 0);
         chk("done", done, ph == 2);
         chk("delcnt", delcnt, m_del[7:0]);
         if (dvalid) chk("dvalid_in_run", ph, 1);
         if (hold) chk("hold", {dvalid, ddata}, {1'b1, hold_d});
         chk("outstanding_le2", (m_iss - m_del) <= 2, 1);
         if (fiford) begin
            chk("rd_legal", {ph == 1, notempty, m_iss < m_len}, 3'b111);
            m_iss++;
         end
         if (dvalid && dready) begin
            chk("order", ddata, mem[exp_idx[7:0]]);
            exp_idx++;
            m_del++;
         end
         hold   = dvalid && !dready;
         hold_d = ddata;
         case (ph)
            0: if (start) begin
               m_len = rdnum; m_del = 0; m_iss = 0;
               ph = (rdnum == 8'd0) ? 2 : 1;
            end
            1: if (m_del == m_len) ph = 2;
            default: ph = 0;
         endcase
      end
   end

   task automatic push_words(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr[7:0]] = base + 8'(i);
         wr_ptr++;
      end
   endtask

   task automatic do_start(input logic [7:0] n);
      rdnum = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rdnum = 8'hAA;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int k = 0;
      while (busy && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_finish"}, busy, 0);
      @(posedge clk); #1;
   endtask

   int first, nw, dt, nrd, k;
   logic [7:0] got [0:4];
   int gt [0:4];

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;

      // T1: 5 words, streaming
      push_words(8'h11, 5);
      dready = 1'b1;
      @(posedge clk); #1;
      do_start(8'd5);
      first = -1; nw = 0; dt = -1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (dvalid) begin
            if (first < 0) first = t;
            if (nw < 5) begin
               got[nw] = ddata;
               gt[nw]  = t;
            end
            nw++;
         end
         if (done) dt = t;
      end
      chk("t1_first_dvalid", first, 2);
      chk("t1_count", nw, 5);
      for (int i = 0; i < 5; i++) begin
         chk("t1_word", got[i], 8'h11 + i);
         chk("t1_word_cycle", gt[i], 2 + i);
      end
      chk("t1_done_cycle", dt, 7);
      chk("t1_delcnt", delcnt, 5);
      @(posedge clk); #1;

      // T2: zero-length transfer with data waiting
      push_words(8'h21, 8);
      do_start(8'd0);
      @(negedge clk);
      chk("t2_done", {done, busy}, 2'b11);
      chk("t2_delcnt", delcnt, 0);
      chk("t2_no_rd", fiford, 0);
      @(negedge clk);
      chk("t2_after", {done, busy, fiford}, 3'b000);
      @(posedge clk); #1;

      // T3: sink stalled for 6 cycles
      dready = 1'b0;
      do_start(8'd8);
      nrd = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (fiford) nrd++;
         if (dvalid) chk("t3_held", ddata, 8'h21);
      end
      chk("t3_rd_le2", nrd <= 2, 1);
      chk("t3_rd_eq2", nrd, 2);
      chk("t3_valid", dvalid, 1);
      @(posedge clk); #1;
      dready = 1'b1;
      wait_idle("t3", 40);
      chk("t3_delcnt", delcnt, 8);

      // T4: FIFO runs dry mid-transfer
      push_words(8'h31, 2);
      do_start(8'd4);
      nrd = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (fiford) nrd++;
      end
      chk("t4_stall_rd", nrd, 2);
      chk("t4_stall_del", {busy, delcnt}, {1'b1, 8'd2});
      @(posedge clk); #1;
      push_words(8'h33, 2);
      wait_idle("t4", 40);
      chk("t4_delcnt", delcnt, 4);

      // T5: start while busy is ignored
      push_words(8'h41, 5);
      do_start(8'd5);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk("t5_busy", busy, 1);
      rdnum = 8'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("t5", 40);
      chk("t5_delcnt", delcnt, 5);

      // T6: reset after the 2nd word
      push_words(8'h51, 8);
      do_start(8'd8);
      k = 0;
      @(negedge clk);
      while (delcnt != 8'd2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("t6_reach2", delcnt, 2);
      #1 rst_ = 1'b0;
      #1;
      chk("t6_rst_outs", {fiford, dvalid, busy, done, ddata, delcnt}, 0);
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk("t6_quiet", {dvalid, busy, fiford}, 3'b000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_rdstream.md
FIFO_RDSTREAM -- requirements
Module: fifo_rdstream

Interface
REQ-001 Parameter WIDTH, default 8, data word width; SHALL match the attached FIFO data width.
REQ-002 Parameter CNTBIT, default 8, width of the transfer-length and delivered-count fields.
REQ-003 Port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  one-cycle request to begin a transfer of rdnum words.
REQ-006 Port rdnum  input  CNTBIT  transfer length; sampled only in the cycle start is accepted.
REQ-007 Port notempty  input  1  FIFO not-empty flag from the attached FIFO.
REQ-008 Port fifodout  input  WIDTH  FIFO read data; valid exactly 1 cycle after a fiford cycle, don't-care otherwise.
REQ-009 Port fiford  output  1  FIFO read strobe.
REQ-010 Port dvalid  output  1  output word valid.
REQ-011 Port ddata  output  WIDTH  output word.
REQ-012 Port dready  input  1  downstream accept; a transfer occurs when dvalid and dready are both high.
REQ-013 Port busy  output  1  high while a transfer is in progress.
REQ-014 Port done  output  1  one-cycle pulse when the last word of a transfer has been accepted.
REQ-015 Port delcnt  output  CNTBIT  number of words accepted downstream in the current or most recent transfer.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; IDLE->RUN on start with rdnum!=0; IDLE->DONE on start with rdnum==0; RUN->DONE when delcnt reaches rdnum through an accepted word; DONE->IDLE unconditionally after 1 cycle.
REQ-017 done SHALL be high only in DONE; busy SHALL be high in RUN and DONE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 Accepting start SHALL clear delcnt to 0, latch rdnum and clear the issued-read counter.
REQ-020 fiford SHALL be asserted only when all of the following hold: state RUN, notempty high, issued reads < latched rdnum, and (buffer occupancy + in-flight read - downstream pop this cycle) < 2.
REQ-021 The block SHALL capture fifodout into a 2-entry output buffer in the cycle after each fiford, and in no other cycle.
REQ-022 Words SHALL leave on ddata in FIFO read order; dvalid SHALL equal buffer-not-empty; ddata SHALL hold the oldest entry, stable while dvalid is high and dready is low.
REQ-023 Capture and pop in the same cycle SHALL preserve order and occupancy.
REQ-024 With dready held high and notempty held high, the block SHALL sustain one word per cycle after an initial latency of 2 cycles (start to first dvalid).
REQ-025 delcnt SHALL increment by 1 on each accepted word; it SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-026 The block SHALL never issue more than rdnum reads per transfer and SHALL never read while notempty is low.
REQ-027 When notempty drops mid-transfer, the block SHALL stall reads and resume when notempty returns, without loss or duplication.

Reset
REQ-028 With rst_ low, the block SHALL return to IDLE and hold fiford, dvalid, busy and done at 0, ddata at 0, delcnt at 0, the buffer empty and the in-flight flag clear.
REQ-029 Reset mid-transfer SHALL discard all buffered and in-flight data; after release the block SHALL wait for a new start.

Structure
REQ-030 The FSM state encodings SHALL live in a shared package and SHALL be reused by any sibling FIFO controller.
REQ-031 The 2-entry output buffer SHALL be a sub-module, rdstream_skid2, with capture/pop ports and a 2-bit occupancy output.

Verification
REQ-032 Reset the block, pre-load the FIFO with 5 words 0x11..0x15, then start with rdnum=5 and dready=1: the bench SHALL see ddata 0x11..0x15 on 5 consecutive cycles, first dvalid 2 cycles after start, done 1 cycle after the last word and delcnt=5.
REQ-033 Start with rdnum=0: the bench SHALL see done high in the next cycle, no fiford and delcnt=0.
REQ-034 Pre-load 8 words, start with rdnum=8, and hold dready low for 6 cycles: the bench SHALL see at most 2 fiford pulses, ddata held at the first word, then all 8 words in order once dready rises.
REQ-035 Pre-load 2 words, start with rdnum=4, then write 2 more words 10 cycles later: the bench SHALL see fiford stall while notempty is low, then 4 words in order with no duplicates.
REQ-036 Assert start again while busy, with rdnum=3: the bench SHALL see no effect on the current transfer count.
REQ-037 Assert rst_ low after the 2nd word of an 8-word transfer: the bench SHALL see all outputs 0 immediately and no dvalid after release until a new start.
